// File: rtl/lu_sequencer_pkg.sv
// Shared opcode constants, FSM encoding and result payload for the logic-unit sequencer.
package lu_sequencer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 2;

  typedef logic [OP_W-1:0]   op_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam op_t OP_OR  = 2'b00;
  localparam op_t OP_AND = 2'b01;
  localparam op_t OP_XOR = 2'b10;
  localparam op_t OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_Y = 2'd1,
    ST_EXEC   = 2'd2,
    ST_OUT    = 2'd3
  } state_e;

  typedef struct packed {
    op_t   op;
    data_t data;
  } result_t;

endpackage

// File: rtl/lu_sequencer_lu.sv
// Existing 8-bit logic unit: OR / AND / XOR / NOT x, purely combinational.
module lu_sequencer_lu
  import lu_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_y,
  input  logic              i_sel1,
  input  logic              i_sel0,
  output logic [DATA_W-1:0] o_f_c
);

  always_comb begin
    o_f_c = '0;
    case ({i_sel1, i_sel0})
      OP_OR:   o_f_c = i_x | i_y;
      OP_AND:  o_f_c = i_x & i_y;
      OP_XOR:  o_f_c = i_x ^ i_y;
      default: o_f_c = ~i_x;
    endcase
  end

endmodule

// File: rtl/lu_sequencer.sv
// Byte-stream sequencer feeding an external 8-bit logic unit: collects x/op and y,
// runs one EXEC cycle, then holds the result until the downstream takes it.
module lu_sequencer
  import lu_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OP_W-1:0]   in_op,
  output logic [DATA_W-1:0] lu_x,
  output logic [DATA_W-1:0] lu_y,
  output logic              lu_sel1,
  output logic              lu_sel0,
  input  logic [DATA_W-1:0] lu_f,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OP_W-1:0]   out_op,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_e           r_state;
  state_e           w_next;
  logic             w_in_xfer;
  logic             w_ld_x;
  logic             w_ld_y;
  logic             w_ld_out;
  logic             w_handoff;

  data_t            r_lu_x;
  data_t            r_lu_y;
  op_t              r_sel;
  result_t          r_out;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  // Next-state and load-enable decode
  always_comb begin
    w_next    = r_state;
    w_ld_x    = 1'b0;
    w_ld_y    = 1'b0;
    w_ld_out  = 1'b0;
    w_handoff = 1'b0;
    w_in_xfer = in_valid && r_in_ready;
    case (r_state)
      ST_IDLE: begin
        if (w_in_xfer) begin
          w_ld_x = 1'b1;
          w_next = (in_op == OP_NOT) ? ST_EXEC : ST_WAIT_Y;
        end
      end
      ST_WAIT_Y: begin
        if (w_in_xfer) begin
          w_ld_y = 1'b1;
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_ld_out = 1'b1;
        w_next   = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          w_handoff = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Status flags are registered from the next state so they line up with r_state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == ST_IDLE) || (w_next == ST_WAIT_Y);
      r_out_valid <= (w_next == ST_OUT);
      r_busy      <= (w_next != ST_IDLE);
    end
  end

  // Operand, result and handoff-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_x <= '0;
      r_lu_y <= '0;
      r_sel  <= OP_OR;
      r_out  <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_ld_x) begin
        r_lu_x <= in_data;
        r_sel  <= in_op;
        if (in_op == OP_NOT) begin
          r_lu_y <= '0;
        end
      end
      if (w_ld_y) begin
        r_lu_y <= in_data;
      end
      if (w_ld_out) begin
        r_out <= '{op: r_sel, data: lu_f};
      end
      if (w_handoff) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign lu_x      = r_lu_x;
  assign lu_y      = r_lu_y;
  assign lu_sel1   = r_sel[1];
  assign lu_sel0   = r_sel[0];
  assign out_data  = r_out.data;
  assign out_op    = r_out.op;
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_lu_sequencer.sv
// Closed-loop bench: sequencer plus logic unit, scoreboard of expected results,
// a second instance with a 2-bit counter driven in lockstep.
module tb_lu_sequencer;
  import lu_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_op;
  logic       out_ready;

  logic       in_ready, out_valid, busy, lu_sel1, lu_sel0;
  logic [7:0] lu_x, lu_y, lu_f, out_data, op_count;
  logic [1:0] out_op;

  logic       in_ready2, out_valid2, busy2, lu_sel1_2, lu_sel0_2;
  logic [7:0] lu_x2, lu_y2, lu_f2, out_data2;
  logic [1:0] out_op2, op_count2;

  always #5 clk = ~clk;

  lu_sequencer #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .lu_x(lu_x), .lu_y(lu_y),
    .lu_sel1(lu_sel1), .lu_sel0(lu_sel0), .lu_f(lu_f), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_op(out_op), .busy(busy),
    .op_count(op_count)
  );
  lu_sequencer_lu u_lu (
    .i_x(lu_x), .i_y(lu_y), .i_sel1(lu_sel1), .i_sel0(lu_sel0), .o_f_c(lu_f)
  );

  lu_sequencer #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_op(in_op), .lu_x(lu_x2), .lu_y(lu_y2),
    .lu_sel1(lu_sel1_2), .lu_sel0(lu_sel0_2), .lu_f(lu_f2), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_op(out_op2), .busy(busy2),
    .op_count(op_count2)
  );
  lu_sequencer_lu u_lu2 (
    .i_x(lu_x2), .i_y(lu_y2), .i_sel1(lu_sel1_2), .i_sel0(lu_sel0_2), .o_f_c(lu_f2)
  );

  typedef struct {
    logic [7:0] x;
    logic [1:0] op;
    logic [7:0] y;
    logic [7:0] exp;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] op;
  } exp_t;

  exp_t sb[$];
  int   hq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL handoff_unexpected: got data %0h want none", out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_op", 32'(out_op), 32'(e.op));
      end
      chk("op_count_before", 32'(op_count), 32'(exp_cnt % 256));
      chk("op_count_w2_before", 32'(op_count2), 32'(exp_cnt % 4));
      exp_cnt++;
      hq.push_back(cyc);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic [1:0] op, output int tries);
    logic acc;
    tries    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    forever begin
      acc = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) break;
      tries++;
      if (tries > 30) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] x, input logic [1:0] op,
                        input logic [7:0] y, input logic [7:0] exp);
    int t;
    push_byte(x, op, t);
    chk("x_accepted", 32'(t <= 30), 1);
    if (op != OP_NOT) begin
      push_byte(y, 2'b11, t);
      chk("y_accepted", 32'(t <= 30), 1);
    end
    sb.push_back('{d: exp, op: op});
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("scoreboard_drained", 32'(sb.size()), 0);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    chk("out_valid_seen", 32'(out_valid), 1);
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_lu_x", 32'(lu_x), 0);
    chk("rst_lu_y", 32'(lu_y), 0);
    chk("rst_sel", 32'({lu_sel1, lu_sel0}), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_op", 32'(out_op), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst2_flags", 32'({in_ready2, out_valid2, busy2}), 32'h4);
    chk("rst2_out", 32'({out_data2, out_op2, op_count2}), 0);
  endtask

  initial begin
    int t;
    tbl[0] = '{8'hA5, OP_OR,  8'h5A, 8'hFF};
    tbl[1] = '{8'hF0, OP_AND, 8'h3C, 8'h30};
    tbl[2] = '{8'hFF, OP_XOR, 8'h0F, 8'hF0};
    tbl[3] = '{8'h00, OP_NOT, 8'h00, 8'hFF};
    tbl[4] = '{8'h3C, OP_NOT, 8'h00, 8'hC3};
    tbl[5] = '{8'h81, OP_OR,  8'h18, 8'h99};
    tbl[6] = '{8'h81, OP_AND, 8'h81, 8'h81};
    tbl[7] = '{8'h55, OP_XOR, 8'h55, 8'h00};

    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_op     = 2'b00;
    out_ready = 1'b0;

    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        #2;
        mon();
      end
      begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
      end
    join_none

    #23;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic OR, first transfer right after reset release
    out_ready = 1'b1;
    push_byte(8'h6C, OP_OR, t);
    chk("first_xfer_tries", 32'(t), 0);
    push_byte(8'h17, 2'b11, t);
    sb.push_back('{d: 8'h7F, op: OP_OR});
    drain();
    chk("op_count_after_first", 32'(op_count), 1);

    // Back-to-back two-operand ops: 4 cycles apart
    hq.delete();
    run_op(8'h6C, OP_AND, 8'h17, 8'h04);
    run_op(8'h6C, OP_XOR, 8'h17, 8'h7B);
    run_op(8'h6C, OP_OR,  8'h17, 8'h7F);
    drain();
    chk("thru2_n", 32'(hq.size()), 3);
    if (hq.size() == 3) begin
      chk("thru2_gap0", 32'(hq[1] - hq[0]), 4);
      chk("thru2_gap1", 32'(hq[2] - hq[1]), 4);
    end

    // Back-to-back NOT: 3 cycles apart
    hq.delete();
    run_op(8'h6C, OP_NOT, 8'h00, 8'h93);
    run_op(8'h00, OP_NOT, 8'h00, 8'hFF);
    drain();
    chk("thru_not_n", 32'(hq.size()), 2);
    if (hq.size() == 2) chk("thru_not_gap", 32'(hq[1] - hq[0]), 3);

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].x, tbl[i].op, tbl[i].y, tbl[i].exp);
    end
    drain();

    // NOT latency, lu_y cleared, no y byte consumed
    out_ready = 1'b0;
    push_byte(8'h6C, OP_NOT, t);
    sb.push_back('{d: 8'h93, op: OP_NOT});
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_op    = OP_OR;
    chk("not_exec_valid", 32'(out_valid), 0);
    chk("not_exec_busy", 32'(busy), 1);
    chk("not_exec_in_ready", 32'(in_ready), 0);
    chk("not_lu_y", 32'(lu_y), 0);
    @(negedge clk);
    chk("not_out_valid", 32'(out_valid), 1);
    chk("not_out_data", 32'(out_data), 32'h93);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Backpressure in OUT for 5 cycles while upstream keeps offering a byte
    out_ready = 1'b0;
    run_op(8'h6C, OP_OR, 8'h17, 8'h7F);
    wait_valid();
    in_valid = 1'b1;
    in_data  = 8'hEE;
    in_op    = OP_NOT;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_data", 32'(out_data), 32'h7F);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    run_op(8'h6C, OP_AND, 8'h17, 8'h04);
    drain();

    // Reset while waiting for y
    push_byte(8'hAA, OP_OR, t);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset();
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push_byte(8'h6C, OP_OR, t);
    chk("after_rst_first_tries", 32'(t), 0);
    push_byte(8'h17, 2'b11, t);
    sb.push_back('{d: 8'h7F, op: OP_OR});
    drain();
    chk("after_rst_wy_count", 32'(op_count), 1);

    // Reset while a result is pending in OUT
    out_ready = 1'b0;
    run_op(8'h6C, OP_XOR, 8'h17, 8'h7B);
    wait_valid();
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset();
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    run_op(8'h6C, OP_AND, 8'h17, 8'h04);
    drain();
    chk("after_rst_out_count", 32'(op_count), 1);
    chk("after_rst_out_count2", 32'(op_count2), 1);

    // Wrap the 2-bit counter: 1,2,3,0,1 checked per handoff
    for (int i = 0; i < 5; i++) begin
      run_op(8'hC3, OP_XOR, 8'hFF, 8'h3C);
    end
    drain();
    chk("wrap_count2", 32'(op_count2), 2);
    chk("wrap_count8", 32'(op_count), 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
